game_timer_ctrl: RTL and testbench
==================================

# game_timer_ctrl

Two-digit BCD countdown controller that sequences the round timer for the game. It sits between the game controller's `timer_reconfig`/`timer_enable` outputs and the seven-segment timer digits, and it returns the `time_out` level that ends a round. It derives a one-second tick from the system clock, loads the round length on reconfigure, counts down while enabled, and holds expiry until it is reconfigured again.

## Interface

Parameters:
- `TICKS_PER_SEC`, default 50_000_000: clock cycles per one-second tick. Must be at least 2.
- `PRESCALE_W`, default 26: prescaler width. Must satisfy 2^PRESCALE_W ≥ TICKS_PER_SEC.
- `LOAD_TENS`, default 4'd9: tens digit loaded on reconfigure. Range 0–9.
- `LOAD_ONES`, default 4'd9: ones digit loaded on reconfigure. Range 0–9.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `timer_reconfig`  in  1: load request. Normally a 1-cycle pulse. Any high cycle reloads.
- `timer_enable`  in  1: level. Count while high, pause while low.
- `tens`  out  4: BCD tens digit, registered.
- `ones`  out  4: BCD ones digit, registered.
- `sec_tick`  out  1: 1-cycle pulse on every decrement.
- `time_out`  out  1: level. High while expired.
- `running`  out  1: high while the prescaler is advancing.

## Operation

States: IDLE, LOADED, COUNTING, EXPIRED.

Reset (`rst`=0, asynchronous):
- state goes to IDLE.
- `tens`=0, `ones`=0, prescaler=0.
- `sec_tick`=0, `time_out`=0, `running`=0.

`timer_reconfig`=1 has the highest priority and applies in any state:
- Next edge: `tens`=LOAD_TENS, `ones`=LOAD_ONES, prescaler=0, `time_out`=0, `sec_tick`=0.
- State goes to LOADED.
- If the load value is 00, state goes to EXPIRED with `time_out`=1 instead.

IDLE:
- `timer_enable` is ignored.
- Digits stay 00 and `time_out` stays 0.
- Only `timer_reconfig` exits this state.

LOADED:
- When `timer_enable`=1, go to COUNTING. The prescaler starts incrementing from this same edge.

COUNTING, with `timer_enable`=1:
- The prescaler increments by 1 each cycle.
- When the prescaler is at TICKS_PER_SEC-1: prescaler goes to 0, `sec_tick`=1 for one cycle, and the BCD value decrements.

COUNTING, with `timer_enable`=0:
- The prescaler and digits hold. No `sec_tick`.
- State stays COUNTING. Counting resumes from the held prescaler value.

BCD decrement:
- If `ones`≠0, then `ones`-1.
- Otherwise `ones`=9 and `tens`-1.
- No binary intermediate. Digits never leave the range 0–9.

Expiry:
- A decrement that produces 00 sets `time_out`=1 and moves to EXPIRED on the same edge.

EXPIRED:
- Digits hold at 00 and `time_out` holds at 1.
- `timer_enable` is ignored and the prescaler is held at 0.
- Only reconfigure or reset exits.

`running` = (state==COUNTING) && `timer_enable`, registered.

## Timing

- Reconfigure: latency 1 edge to loaded digits, with `time_out` low on that same edge.
- Count start: the first `sec_tick` comes TICKS_PER_SEC enabled cycles after the first COUNTING cycle.
- Full round: `time_out` rises exactly (10·LOAD_TENS+LOAD_ONES)·TICKS_PER_SEC enabled cycles after entering COUNTING. Paused cycles do not count.
- Final decrement: `time_out`, `sec_tick` and digits=00 all update on the same edge.
- Reconfigure in the same cycle as the terminal tick: reconfigure wins. No `sec_tick`, `time_out` stays 0, digits are loaded.
- Reconfigure and `timer_enable` high together: go to LOADED. `timer_enable` is sampled again on the next cycle, so counting starts 1 cycle later.
- `timer_enable` dropping on the terminal-count cycle: the tick is not taken. The prescaler holds at TICKS_PER_SEC-1 and fires on the next enabled cycle.
- Reset asserted mid-count: outputs clear immediately, without waiting for `clk`. After release, the block stays in IDLE until reconfigured.

## Test plan

All scenarios use TICKS_PER_SEC=4, LOAD=99.

1. Reset then idle: assert `rst`=0 mid-cycle, hold `timer_enable`=1 for 20 cycles after release. Required: outputs clear asynchronously; digits stay 00; `time_out`=0; no `sec_tick`.
2. Load and count: pulse reconfig, then `timer_enable`=1. Required: 9/9 on the next edge; 9/8 and `sec_tick` after 4 cycles; 8/9 after 40 cycles; tens borrow occurs exactly once.
3. Full round: enable continuously. Required: `time_out` rises exactly 396 cycles after entering COUNTING with digits 0/0; it stays high for 50 more cycles; `timer_enable` toggling has no effect.
4. Pause: drop `timer_enable` for 7 cycles when the prescaler is at 2, then re-enable. Required: digits frozen and `running`=0 during the pause; the next tick arrives 2 enabled cycles after resume, so the total is 403 cycles.
5. Reconfigure collisions: (a) reconfig on the terminal-count cycle at 0/1 gives digits 9/9, `time_out`=0, no tick; (b) reconfig while EXPIRED clears `time_out` next edge and digits become 9/9.
6. Parameter variant LOAD=00: reconfig gives `time_out`=1 on the next edge. Separately, LOAD=10 reaches 0/9 then 0/0 with `time_out` after 40 cycles.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// Two-digit BCD round timer: one-second prescaler, reload on reconfigure,
// countdown while enabled, sticky expiry until the next reconfigure.
module game_timer_ctrl #(
  parameter int          TICKS_PER_SEC = 50_000_000,
  parameter int          PRESCALE_W    = 26,
  parameter logic [3:0]  LOAD_TENS     = 4'd9,
  parameter logic [3:0]  LOAD_ONES     = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       timer_reconfig,
  input  logic       timer_enable,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       sec_tick,
  output logic       time_out,
  output logic       running
);

  // state      | meaning
  // S_IDLE     | after reset, digits 00, waits for reconfigure
  // S_LOADED   | round length loaded, waits for enable
  // S_COUNTING | prescaler advances while enabled, digits count down
  // S_EXPIRED  | digits 00, time_out held until reconfigure
  typedef enum logic [1:0] {S_IDLE, S_LOADED, S_COUNTING, S_EXPIRED} state_t;

  localparam logic [PRESCALE_W-1:0] TERM      = PRESCALE_W'(TICKS_PER_SEC - 1);
  localparam logic [PRESCALE_W-1:0] ONE       = PRESCALE_W'(1);
  localparam logic                  LOAD_ZERO = (LOAD_TENS == 4'd0) && (LOAD_ONES == 4'd0);

  state_t                r_state, w_state_nxt;
  logic [PRESCALE_W-1:0] r_presc, w_presc_nxt;
  logic [3:0]            r_tens,  w_tens_nxt;
  logic [3:0]            r_ones,  w_ones_nxt;
  logic                  r_tick,  w_tick_nxt;
  logic                  r_tout,  w_tout_nxt;
  logic                  r_run,   w_run_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_presc <= '0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_tick  <= 1'b0;
      r_tout  <= 1'b0;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_tick  <= w_tick_nxt;
      r_tout  <= w_tout_nxt;
      r_run   <= w_run_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = r_presc;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_tick_nxt  = 1'b0;
    w_tout_nxt  = r_tout;
    w_run_nxt   = 1'b0;

    if (timer_reconfig) begin
      w_tens_nxt  = LOAD_TENS;
      w_ones_nxt  = LOAD_ONES;
      w_presc_nxt = '0;
      w_tout_nxt  = LOAD_ZERO;
      w_state_nxt = LOAD_ZERO ? S_EXPIRED : S_LOADED;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_tout_nxt = 1'b0;
        end
        S_LOADED: begin
          if (timer_enable) begin
            w_state_nxt = S_COUNTING;
            w_presc_nxt = r_presc + ONE;
          end
        end
        S_COUNTING: begin
          if (timer_enable) begin
            w_run_nxt = 1'b1;
            if (r_presc == TERM) begin
              w_presc_nxt = '0;
              w_tick_nxt  = 1'b1;
              // BCD borrow directly on the digits, no binary intermediate
              if (r_ones != 4'd0) begin
                w_ones_nxt = r_ones - 4'd1;
              end else begin
                w_ones_nxt = 4'd9;
                w_tens_nxt = r_tens - 4'd1;
              end
              if ((r_tens == 4'd0) && (r_ones == 4'd1)) begin
                w_tout_nxt  = 1'b1;
                w_state_nxt = S_EXPIRED;
              end
            end else begin
              w_presc_nxt = r_presc + ONE;
            end
          end
        end
        S_EXPIRED: begin
          w_presc_nxt = '0;
          w_tout_nxt  = 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign tens     = r_tens;
  assign ones     = r_ones;
  assign sec_tick = r_tick;
  assign time_out = r_tout;
  assign running  = r_run;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Bench for game_timer_ctrl with TICKS_PER_SEC=4: expected ticks are queued by
// the stimulus and popped by a monitor whenever sec_tick is seen.
module tb_game_timer_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] t;
    logic [3:0] o;
    logic       to;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rcfg, en;
  logic [3:0] tens, ones;
  logic       sec_tick, time_out, running;
  logic       rcfg_z, en_z;
  logic [3:0] tens_z, ones_z;
  logic       tick_z, tout_z, run_z;
  logic       rcfg_t, en_t;
  logic [3:0] tens_t, ones_t;
  logic       tick_t, tout_t, run_t;

  int   cyc;
  int   checks;
  int   errors;
  int   ticks_seen;
  exp_t sb[$];

  game_timer_ctrl #(.TICKS_PER_SEC(4), .PRESCALE_W(3), .LOAD_TENS(4'd9), .LOAD_ONES(4'd9)) u_dut (
    .clk(clk), .rst(rst), .timer_reconfig(rcfg), .timer_enable(en),
    .tens(tens), .ones(ones), .sec_tick(sec_tick), .time_out(time_out), .running(running)
  );

  game_timer_ctrl #(.TICKS_PER_SEC(4), .PRESCALE_W(3), .LOAD_TENS(4'd0), .LOAD_ONES(4'd0)) u_zero (
    .clk(clk), .rst(rst), .timer_reconfig(rcfg_z), .timer_enable(en_z),
    .tens(tens_z), .ones(ones_z), .sec_tick(tick_z), .time_out(tout_z), .running(run_z)
  );

  game_timer_ctrl #(.TICKS_PER_SEC(4), .PRESCALE_W(3), .LOAD_TENS(4'd1), .LOAD_ONES(4'd0)) u_ten (
    .clk(clk), .rst(rst), .timer_reconfig(rcfg_t), .timer_enable(en_t),
    .tens(tens_t), .ones(ones_t), .sec_tick(tick_t), .time_out(tout_t), .running(run_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every sec_tick of the main instance must match the queue head
  always @(negedge clk) begin
    if (rst && sec_tick) begin
      ticks_seen = ticks_seen + 1;
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL tick_unexpected: got tick at cyc=%0d digits=%0d/%0d, required no tick", cyc, tens, ones);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.t !== tens || e.o !== ones || e.to !== time_out) begin
          errors = errors + 1;
          $display("FAIL tick_%0d: got cyc=%0d %0d/%0d to=%0b, required cyc=%0d %0d/%0d to=%0b",
                   ticks_seen, cyc, tens, ones, time_out, e.cyc, e.t, e.o, e.to);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tick(input int c, input int k);
    exp_t e;
    int   v;
    v    = 99 - k;
    e.cyc = c;
    e.t  = 4'(v / 10);
    e.o  = 4'(v % 10);
    e.to = (v == 0);
    sb.push_back(e);
  endtask

  int m;

  initial begin
    cyc = 0; checks = 0; errors = 0; ticks_seen = 0;
    rst = 1'b0; rcfg = 1'b0; en = 1'b0;
    rcfg_z = 1'b0; en_z = 1'b0; rcfg_t = 1'b0; en_t = 1'b0;
    #2;
    chk("reset_outputs", {tens, ones, sec_tick, time_out, running}, 32'd0);
    repeat (2) step();
    rst = 1'b1;

    // 1: idle ignores enable
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_outputs", {tens, ones, sec_tick, time_out, running}, 32'd0);
    end

    // 2/3: load and full round
    en = 1'b0; rcfg = 1'b1;
    step();
    rcfg = 1'b0;
    chk("load_99", {tens, ones, time_out, sec_tick}, {4'd9, 4'd9, 1'b0, 1'b0});
    m = cyc;
    for (int k = 1; k <= 99; k++) push_tick(m + 4 * k, k);
    en = 1'b1;
    for (int i = 1; i <= 396; i++) begin
      step();
      if (i == 4)   chk("first_tick_98", {tens, ones, sec_tick}, {4'd9, 4'd8, 1'b1});
      if (i == 40)  chk("borrow_89", {tens, ones}, {4'd8, 4'd9});
      if (i == 395) chk("no_early_timeout", {28'd0, time_out}, 32'd0);
      if (i == 396) chk("timeout_at_396", {tens, ones, time_out, sec_tick}, {4'd0, 4'd0, 1'b1, 1'b1});
    end
    for (int i = 0; i < 50; i++) begin
      en = i[0];
      step();
      chk("expired_hold", {tens, ones, time_out, running}, {4'd0, 4'd0, 1'b1, 1'b0});
    end
    chk("round1_queue_empty", sb.size(), 32'd0);

    // 5b + 4: reconfigure from EXPIRED, then pause at prescaler 2
    en = 1'b0; rcfg = 1'b1;
    step();
    rcfg = 1'b0;
    chk("reload_from_expired", {tens, ones, time_out}, {4'd9, 4'd9, 1'b0});
    m = cyc;
    for (int k = 1; k <= 98; k++) push_tick(m + 4 * k + 7, k);
    en = 1'b1;
    step(); step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("pause_frozen", {tens, ones, running, sec_tick}, {4'd9, 4'd9, 1'b0, 1'b0});
    end
    en = 1'b1;
    step();
    chk("resume_running", {28'd0, running}, 32'd1);
    step();
    chk("resume_tick_98", {tens, ones, sec_tick}, {4'd9, 4'd8, 1'b1});
    while (cyc < m + 402) step();
    chk("at_01_before_terminal", {tens, ones, time_out}, {4'd0, 4'd1, 1'b0});

    // 5a: reconfigure on the terminal-count cycle wins
    rcfg = 1'b1;
    step();
    rcfg = 1'b0;
    chk("reconfig_wins_terminal", {tens, ones, time_out, sec_tick}, {4'd9, 4'd9, 1'b0, 1'b0});
    chk("round2_queue_empty", sb.size(), 32'd0);

    // Mid-count async reset
    m = cyc;
    push_tick(m + 4, 1);
    repeat (5) step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_clear", {tens, ones, sec_tick, time_out, running}, 32'd0);
    #3;
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("post_reset_idle", {tens, ones, sec_tick, time_out}, 32'd0);
    end
    en = 1'b0;
    chk("reset_queue_empty", sb.size(), 32'd0);

    // 6: LOAD=00 expires on reconfigure
    rcfg_z = 1'b1;
    step();
    rcfg_z = 1'b0;
    chk("zero_load_timeout", {tens_z, ones_z, tout_z}, {4'd0, 4'd0, 1'b1});
    en_z = 1'b1;
    repeat (6) step();
    chk("zero_load_hold", {tens_z, ones_z, tout_z, tick_z}, {4'd0, 4'd0, 1'b1, 1'b0});

    // 6: LOAD=10 counts to 0/9 then 0/0
    rcfg_t = 1'b1;
    step();
    rcfg_t = 1'b0;
    chk("ten_load", {tens_t, ones_t, tout_t}, {4'd1, 4'd0, 1'b0});
    en_t = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 4)  chk("ten_borrow_09", {tens_t, ones_t, tick_t}, {4'd0, 4'd9, 1'b1});
      if (i == 39) chk("ten_no_early_timeout", {28'd0, tout_t}, 32'd0);
      if (i == 40) chk("ten_timeout_40", {tens_t, ones_t, tout_t, tick_t}, {4'd0, 4'd0, 1'b1, 1'b1});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
